// File: rtl/nec_prefetch_pkg.sv
// Shared types for the NEC instruction prefetch unit and its neighbours.
// Contents: queue depth constant, prefetch FSM state enum, and the
// segment:offset to 20-bit physical address helper, which the execution unit also uses.
package nec_prefetch_pkg;

  // Depth of the instruction prefetch queue in bytes. The decoder indexes it
  // with offset[2:0], so this must stay a power of 2.
  localparam int IPQ_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } prefetch_state_e;

  // Physical address = (seg << 4) + ofs, wrapping modulo 2^20.
  function automatic logic [19:0] phys_addr(input logic [15:0] seg,
                                            input logic [15:0] ofs);
    return {seg, 4'h0} + {4'h0, ofs};
  endfunction

endpackage

// File: rtl/nec_prefetch.sv
// Instruction prefetch unit: fills an 8-byte circular queue (IPQ) from the
// program segment so that nec_decode can read opcode bytes by its own pc.
// Ports: clk/reset (sync, active-high), ce_1/ce_2 clock enables, ps/decode_pc/new_pc/set_pc
// from the core, block_prefetch inhibit, ipq/ipq_len to the decoder,
// bus_req/bus_addr/bus_ack/bus_data to the CPU bus (one request in flight).
module nec_prefetch
  import nec_prefetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce_1,
  input  logic                     ce_2,
  input  logic [15:0]              ps,
  input  logic [15:0]              decode_pc,
  input  logic [15:0]              new_pc,
  input  logic                     set_pc,
  input  logic                     block_prefetch,
  output logic [IPQ_SIZE-1:0][7:0] ipq,
  output logic [3:0]               ipq_len,
  output logic                     bus_req,
  output logic [19:0]              bus_addr,
  input  logic                     bus_ack,
  input  logic [15:0]              bus_data
);

  prefetch_state_e           state_q, state_d;
  logic [15:0]               fetch_ip_q, fetch_ip_d;
  logic                      bus_req_q, bus_req_d;
  logic [19:0]               bus_addr_q, bus_addr_d;
  logic [IPQ_SIZE-1:0][7:0]  ipq_q, ipq_d;

  logic       en;
  logic [3:0] free;
  logic [3:0] need;
  logic [2:0] idx;
  logic [2:0] idx_nxt;

  assign en = ce_1 | ce_2;

  // fetch_ip - decode_pc never exceeds 8, so the low nibble of the
  // difference is the full answer.
  assign ipq_len = fetch_ip_q[3:0] - decode_pc[3:0];
  assign free    = 4'd8 - ipq_len;
  // An odd fetch_ip only delivers the high byte of its word.
  assign need    = fetch_ip_q[0] ? 4'd1 : 4'd2;
  assign idx     = fetch_ip_q[2:0];
  assign idx_nxt = idx + 3'd1;

  always_comb begin
    state_d    = state_q;
    fetch_ip_d = fetch_ip_q;
    bus_req_d  = bus_req_q;
    bus_addr_d = bus_addr_q;
    ipq_d      = ipq_q;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (set_pc) begin
            fetch_ip_d = new_pc;
          end else if (!block_prefetch && (free >= need)) begin
            bus_req_d  = 1'b1;
            bus_addr_d = phys_addr(ps, {fetch_ip_q[15:1], 1'b0});
            state_d    = FETCH;
          end
        end

        FETCH: begin
          if (bus_ack) begin
            bus_req_d = 1'b0;
            state_d   = IDLE;
            if (set_pc) begin
              // Flush races the returning data: the data is for the old stream.
              fetch_ip_d = new_pc;
            end else if (fetch_ip_q[0]) begin
              ipq_d[idx] = bus_data[15:8];
              fetch_ip_d = fetch_ip_q + 16'd1;
            end else begin
              ipq_d[idx]     = bus_data[7:0];
              ipq_d[idx_nxt] = bus_data[15:8];
              fetch_ip_d     = fetch_ip_q + 16'd2;
            end
          end else if (set_pc) begin
            // The bus cycle cannot be withdrawn; wait it out and drop the data.
            fetch_ip_d = new_pc;
            state_d    = DISCARD;
          end
        end

        DISCARD: begin
          if (set_pc) begin
            fetch_ip_d = new_pc;
          end
          if (bus_ack) begin
            bus_req_d = 1'b0;
            state_d   = IDLE;
          end
        end

        default: begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_ip_q <= 16'h0000;
      bus_req_q  <= 1'b0;
      bus_addr_q <= 20'h00000;
      ipq_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_ip_q <= fetch_ip_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      ipq_q      <= ipq_d;
    end
  end

  assign ipq      = ipq_q;
  assign bus_req  = bus_req_q;
  assign bus_addr = bus_addr_q;

endmodule

// File: tb/tb_nec_prefetch.sv
// Self-checking bench for nec_prefetch: directed sequences with a bus-address
// scoreboard checked by an independent request monitor.
module tb_nec_prefetch;

  logic             clk = 1'b0;
  logic             reset;
  logic             ce_1;
  logic             ce_2;
  logic [15:0]      ps;
  logic [15:0]      decode_pc;
  logic [15:0]      new_pc;
  logic             set_pc;
  logic             block_prefetch;
  logic [7:0][7:0]  ipq;
  logic [3:0]       ipq_len;
  logic             bus_req;
  logic [19:0]      bus_addr;
  logic             bus_ack;
  logic [15:0]      bus_data;

  int tests = 0;
  int fails = 0;

  logic [19:0] exp_addr_q[$];
  logic        mon_prev;
  logic [19:0] mon_held;
  logic [19:0] mon_exp;

  always #5 clk = ~clk;

  nec_prefetch dut (
    .clk            (clk),
    .reset          (reset),
    .ce_1           (ce_1),
    .ce_2           (ce_2),
    .ps             (ps),
    .decode_pc      (decode_pc),
    .new_pc         (new_pc),
    .set_pc         (set_pc),
    .block_prefetch (block_prefetch),
    .ipq            (ipq),
    .ipq_len        (ipq_len),
    .bus_req        (bus_req),
    .bus_addr       (bus_addr),
    .bus_ack        (bus_ack),
    .bus_data       (bus_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (!bus_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (!bus_req) begin
      fails++;
      $display("FAIL %s: bus_req timeout, got 0 expected 1", name);
    end
  endtask

  // Acknowledge the outstanding request after dly cycles, for one cycle.
  task automatic do_ack(input int dly, input logic [15:0] d);
    cyc(dly);
    bus_ack  = 1'b1;
    bus_data = d;
    @(negedge clk);
    bus_ack  = 1'b0;
    chk("req_drop_after_ack", 64'(bus_req), 64'(0));
  endtask

  // Monitor: every new request is checked against the scoreboard; the address
  // must then hold for as long as the request stays up.
  initial begin
    mon_prev = 1'b0;
    mon_held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        mon_prev = 1'b0;
      end else begin
        if (bus_req && !mon_prev) begin
          if (exp_addr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_req: got addr %h expected no request", bus_addr);
          end else begin
            mon_exp = exp_addr_q.pop_front();
            chk("bus_addr", 64'(bus_addr), 64'(mon_exp));
          end
          mon_held = bus_addr;
        end else if (bus_req) begin
          chk("bus_addr_stable", 64'(bus_addr), 64'(mon_held));
        end
        mon_prev = bus_req;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lo, hi;
    reset = 1'b1; ce_1 = 1'b1; ce_2 = 1'b0;
    ps = 16'h1000; decode_pc = 16'h0000; new_pc = 16'h0000;
    set_pc = 1'b0; block_prefetch = 1'b0; bus_ack = 1'b0; bus_data = 16'h0000;

    // Sequential fill from reset
    exp_addr_q.push_back(20'h10000);
    exp_addr_q.push_back(20'h10002);
    exp_addr_q.push_back(20'h10004);
    exp_addr_q.push_back(20'h10006);
    cyc(3);
    chk("rst_bus_req", 64'(bus_req), 64'(0));
    chk("rst_ipq_len", 64'(ipq_len), 64'(0));
    chk("rst_ipq", 64'(ipq), 64'(0));
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lo = 8'(17 + 34 * k);
      hi = 8'(34 + 34 * k);
      wait_req("fill_req");
      do_ack(2, {hi, lo});
      chk("fill_len", 64'(ipq_len), 64'(2 * (k + 1)));
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("full_no_req", 64'(bus_req), 64'(0));
    end
    chk("fill_ipq_lo", 64'(ipq[3:0]), 64'(32'h44332211));
    chk("fill_ipq_hi", 64'(ipq[7:4]), 64'(32'h88776655));

    // Full queue: one free byte is not enough for an even word fetch
    decode_pc = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("free1_no_req", 64'(bus_req), 64'(0));
    end
    chk("free1_len", 64'(ipq_len), 64'(7));
    exp_addr_q.push_back(20'h10008);
    decode_pc = 16'h0002;
    wait_req("free2_req");
    do_ack(1, 16'hAA99);
    chk("free2_len", 64'(ipq_len), 64'(8));
    chk("free2_ipq", 64'(ipq[1:0]), 64'(16'hAA99));

    // Flush to an odd offset
    ps = 16'h0000;
    exp_addr_q.push_back(20'h00004);
    exp_addr_q.push_back(20'h00006);
    exp_addr_q.push_back(20'h00100);
    set_pc = 1'b1; new_pc = 16'h0005; decode_pc = 16'h0005;
    @(negedge clk);
    set_pc = 1'b0;
    chk("flush_no_req", 64'(bus_req), 64'(0));
    chk("flush_len", 64'(ipq_len), 64'(0));
    wait_req("odd_req");
    do_ack(2, 16'hBBAA);
    chk("odd_ipq5", 64'(ipq[5]), 64'(8'hBB));
    chk("odd_len", 64'(ipq_len), 64'(1));

    // Flush while a fetch is in flight: the late data must be dropped
    wait_req("next_req");
    cyc(1);
    set_pc = 1'b1; new_pc = 16'h0100; decode_pc = 16'h0100;
    @(negedge clk);
    set_pc = 1'b0;
    chk("discard_req_held", 64'(bus_req), 64'(1));
    cyc(2);
    do_ack(0, 16'hDDCC);
    chk("discard_len", 64'(ipq_len), 64'(0));
    chk("discard_ipq", 64'(ipq[7:6]), 64'(16'h8877));
    wait_req("after_discard_req");
    cyc(2);
    block_prefetch = 1'b1;
    do_ack(0, 16'h1234);
    chk("after_discard_len", 64'(ipq_len), 64'(2));
    chk("after_discard_ipq", 64'(ipq[1:0]), 64'(16'h1234));

    // block_prefetch with an empty queue, then release with enables low
    set_pc = 1'b1; new_pc = 16'h0200; decode_pc = 16'h0200;
    @(negedge clk);
    set_pc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("blocked_no_req", 64'(bus_req), 64'(0));
    end
    chk("blocked_len", 64'(ipq_len), 64'(0));
    exp_addr_q.push_back(20'h00200);
    ce_1 = 1'b0;
    block_prefetch = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_enable_no_req", 64'(bus_req), 64'(0));
    end
    ce_2 = 1'b1;
    @(negedge clk);
    chk("ce2_req", 64'(bus_req), 64'(1));
    ce_1 = 1'b1; ce_2 = 1'b0;
    cyc(1);
    block_prefetch = 1'b1;
    do_ack(0, 16'h6655);
    chk("unblock_len", 64'(ipq_len), 64'(2));

    // Wrap at 16'hFFFF and at the top of the 20-bit address space
    ps = 16'hF000;
    exp_addr_q.push_back(20'hFFFFE);
    exp_addr_q.push_back(20'hF0000);
    set_pc = 1'b1; new_pc = 16'hFFFF; decode_pc = 16'hFFFF;
    @(negedge clk);
    set_pc = 1'b0;
    block_prefetch = 1'b0;
    wait_req("wrap_req");
    do_ack(1, 16'hEE77);
    chk("wrap_ipq7", 64'(ipq[7]), 64'(8'hEE));
    chk("wrap_len", 64'(ipq_len), 64'(1));
    wait_req("wrap_next_req");
    cyc(1);
    decode_pc = 16'h0000;
    block_prefetch = 1'b1;
    do_ack(0, 16'h3322);
    chk("wrap_consume_len", 64'(ipq_len), 64'(2));
    chk("wrap_ipq01", 64'(ipq[1:0]), 64'(16'h3322));

    cyc(3);
    chk("scoreboard_empty", 64'(exp_addr_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nec_prefetch.md
Name: nec_prefetch

Overview:
Instruction prefetch unit feeding nec_decode. It fetches opcode bytes from the program segment over the CPU bus into an 8-byte circular queue (IPQ). The IPQ is indexed by the low 3 bits of each byte's offset, and the decoder reads it using its own pc. The block tracks decoder consumption through decode_pc, flushes on set_pc, and honours block_prefetch.

Parameters:
IPQ_SIZE, 8, queue depth in bytes; fixed, must be a power of 2 and match decoder indexing.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ce_1  in  1  phase-1 clock enable
ce_2  in  1  phase-2 clock enable
ps  in  16  program segment register
decode_pc  in  16  decoder's current pc (next byte to consume)
new_pc  in  16  flush target offset
set_pc  in  1  flush request (same strobe the decoder sees)
block_prefetch  in  1  inhibits issuing new fetches
ipq  out  8x8  queue storage; byte at offset A lives in ipq[A[2:0]]
ipq_len  out  4  valid bytes from decode_pc onward (0..8)
bus_req  out  1  fetch request, held until bus_ack
bus_addr  out  20  physical word address: (ps<<4) + {fetch_ip[15:1],1'b0}, mod 2^20
bus_ack  in  1  bus_data valid this cycle; request complete
bus_data  in  16  fetched word, little-endian

Behaviour:
- State advances only on cycles with (ce_1 | ce_2). Reset applies on any clk edge where reset=1, regardless of enables.
- Reset values: fetch_ip=0, state=IDLE, bus_req=0, all ipq bytes=8'h00, discard=0. ipq_len follows from fetch_ip and decode_pc.
- ipq_len is combinational: ipq_len = (fetch_ip - decode_pc)[3:0].
  - Invariant: fetch_ip - decode_pc never exceeds 8, modulo 2^16.
- free = 8 - ipq_len. need = fetch_ip[0] ? 1 : 2.
- States are IDLE, FETCH and DISCARD.
- IDLE → FETCH when all of the following hold: !set_pc, !block_prefetch, free >= need.
  - On that cycle, assert bus_req and latch bus_addr.
  - bus_addr is stable while bus_req=1.
- FETCH, bus_ack=1, no set_pc:
  - Even fetch_ip: ipq[fetch_ip[2:0]] <= bus_data[7:0]; ipq[fetch_ip[2:0]+1] <= bus_data[15:8]; fetch_ip += 2.
  - Odd fetch_ip: ipq[fetch_ip[2:0]] <= bus_data[15:8]; fetch_ip += 1.
  - Deassert bus_req and go to IDLE. A new request may issue in the following enabled cycle.
  - First new byte is visible in ipq_len one enabled cycle after the ack.
- FETCH, set_pc=1 without bus_ack:
  - Keep bus_req until ack; the bus request cannot be cancelled. Go to DISCARD.
  - fetch_ip <= new_pc.
- FETCH, set_pc=1 and bus_ack=1 in the same cycle: data is dropped, fetch_ip <= new_pc, go to IDLE.
- DISCARD: on bus_ack, drop bus_data, deassert bus_req, go to IDLE.
  - Another set_pc in DISCARD updates fetch_ip only.
- IDLE with set_pc: fetch_ip <= new_pc. No request is issued that cycle.
- After any flush, ipq_len reads 0, because the decoder's pc also loads new_pc. Stale ipq contents are never cleared.
- block_prefetch only gates new issues. An outstanding fetch still completes and writes.
- Wrap-around:
  - fetch_ip wraps 16'hFFFF → 0.
  - An odd fetch_ip=16'hFFFF fetches one byte, then continues at 0.
  - bus_addr wraps mod 2^20.
  - Queue index wraps 7 → 0.
- Decoder consumption in the same cycle as an ack is legal; ipq_len reflects both.
- At most one bus request is outstanding.

Decomposition:
- Add prefetch_state_e (IDLE, FETCH, DISCARD) and the IPQ_SIZE constant to the types package.
- The physical address calculation (seg<<4 + ofs) is a shared function in types. The execution unit needs the same calculation.
- No sub-module; single flat module.

Test Plan:
- Reset, ps=16'h1000, decode_pc=0, ack each request after 2 cycles with data 16'h2211, 16'h4433, … → addresses 20'h10000, 10002, 10004, 10006. ipq_len steps 2, 4, 6, 8, then no further bus_req.
- Flush with set_pc, new_pc=16'h0005, ps=0 → first request has bus_addr=20'h00004. On ack with data 16'hBBAA, ipq[5]=8'hBB and ipq_len=1. Next request goes to addr 20'h00006.
- Full queue (len=8), decoder advances decode_pc by 1 → still no request (free=1, need=2 at even fetch_ip). Advance by 2 → request issues.
- set_pc while in FETCH, ack arrives 3 cycles later → data not written, ipq_len stays 0. Next request targets the new_pc word.
- block_prefetch=1 with an empty queue → bus_req stays 0 for 10 cycles. Release it → bus_req on the next enabled cycle.
- new_pc=16'hFFFF, ps=16'hF000 → bus_addr=20'hFFFFE, one byte loaded. Next request bus_addr=20'hF0000, fetch_ip=0.
